// File: rtl/loop_nest_pkg.sv
// Shared types and helpers for the nested loop counter.
package loop_nest_pkg;

  typedef enum logic [1:0] {
    LN_IDLE  = 2'd0,
    LN_ARMED = 2'd1,
    LN_RUN   = 2'd2
  } ln_state_e;

  // Deepest nest the sequencer is expected to program.
  localparam int LN_MAX_LEVELS = 8;

  // Working width for trip-count arithmetic; callers cast down to their index width.
  localparam int LN_EB_W = 64;

  // A trip count of zero behaves as a single iteration.
  function automatic logic [LN_EB_W-1:0] eff_bound(input logic [LN_EB_W-1:0] bound);
    return (bound == '0) ? LN_EB_W'(1) : bound;
  endfunction

endpackage

// File: rtl/loop_level.sv
// One loop level: an index register and the address this level's sub-nest starts from.
module loop_level
  import loop_nest_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  bound,
  input  logic [ADDR_W-1:0] stride,
  input  logic              carry_in,
  input  logic              pivot,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] new_base,
  output logic [WIDTH-1:0]  idx,
  output logic              at_end,
  output logic [ADDR_W-1:0] lb
);

  logic [WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] lb_q, lb_d;
  logic [WIDTH-1:0]  last_idx;

  // Final index value for this level, with a zero bound treated as one.
  always_comb begin
    last_idx = WIDTH'(eff_bound(LN_EB_W'(bound)) - LN_EB_W'(1));
  end

  assign at_end = (idx_q == last_idx);
  assign idx    = idx_q;
  assign lb     = lb_q;

  // Reload on start or when a higher level advances; count up when this level is the pivot.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    idx_d = idx_q;
    lb_d  = lb_q;
    if (load_base) begin
      idx_d = '0;
      lb_d  = new_base;
    end else if (pivot && carry_in) begin
      // carry_in is implied by pivot; gating here keeps a level from moving while a lower one is mid-count.
      idx_d = idx_q + WIDTH'(1);
      lb_d  = lb_q + stride;
    end
  end

  // Level state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      idx_q <= '0;
      lb_q  <= '0;
    end else begin
      idx_q <= idx_d;
      lb_q  <= lb_d;
    end
  end

endmodule

// File: rtl/loop_nest_counter.sv
// N-level nested loop counter with per-level address strides for the tile sequencer.
module loop_nest_counter
  import loop_nest_pkg::*;
#(
  parameter int LEVELS = 3,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [LEVELS-1:0][WIDTH-1:0]  cfg_bound,
  input  logic [LEVELS-1:0][ADDR_W-1:0] cfg_stride,
  input  logic [ADDR_W-1:0]             cfg_base,
  input  logic                          start,
  input  logic                          step,
  input  logic                          abort,
  output logic [LEVELS-1:0][WIDTH-1:0]  idx,
  output logic [ADDR_W-1:0]             addr,
  output logic [LEVELS-1:0]             wrap,
  output logic                          last,
  output logic                          busy,
  output logic                          done
);

  ln_state_e state_q, state_d;

  logic [LEVELS-1:0][WIDTH-1:0]  bound_q, bound_d;
  logic [LEVELS-1:0][ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic                          done_q, done_d;

  logic                          run;
  logic                          cfg_fire;
  logic                          start_fire;
  logic                          abort_fire;
  logic                          step_fire;
  logic                          advance;
  logic                          finish;
  logic                          last_w;

  logic [LEVELS-1:0]             at_end;
  logic [LEVELS-1:0]             wrap_c;
  logic [LEVELS-1:0]             carry;
  logic [LEVELS-1:0]             pivot_oh;
  logic [LEVELS-1:0]             load_base;
  logic [ADDR_W-1:0]             new_lb;
  logic [ADDR_W-1:0]             level_base;
  logic [LEVELS-1:0][WIDTH-1:0]  idx_w;
  logic [LEVELS-1:0][ADDR_W-1:0] lb_w;

  // Qualify the control inputs against the current state; abort wins over step.
  always_comb begin
    run        = (state_q == LN_RUN);
    cfg_fire   = cfg_valid && !run;
    start_fire = start && (state_q == LN_ARMED) && !cfg_fire;
    abort_fire = abort && run;
    step_fire  = step && run && !abort;
    last_w     = wrap_c[LEVELS-1] && run;
    advance    = step_fire && !last_w;
    finish     = step_fire && last_w;
  end

  // Wrap chain and pivot priority encoder: the pivot is the lowest level not yet wrapped.
  always_comb begin
    wrap_c[0] = at_end[0];
    carry[0]  = 1'b1;
    for (int k = 1; k < LEVELS; k++) begin
      wrap_c[k] = wrap_c[k-1] && at_end[k];
      carry[k]  = wrap_c[k-1];
    end
    new_lb = '0;
    for (int k = 0; k < LEVELS; k++) begin
      pivot_oh[k]  = advance && carry[k] && !wrap_c[k];
      load_base[k] = start_fire || (advance && wrap_c[k]);
      if (pivot_oh[k]) begin
        new_lb = lb_w[k] + stride_q[k];
      end
    end
    level_base = start_fire ? base_q : new_lb;
  end

  for (genvar g = 0; g < LEVELS; g++) begin : g_level
    loop_level #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .bound     (bound_q[g]),
      .stride    (stride_q[g]),
      .carry_in  (carry[g]),
      .pivot     (pivot_oh[g]),
      .load_base (load_base[g]),
      .new_base  (level_base),
      .idx       (idx_w[g]),
      .at_end    (at_end[g]),
      .lb        (lb_w[g])
    );
  end

  // Next state, configuration capture and completion pulse.
  always_comb begin
    state_d  = state_q;
    bound_d  = bound_q;
    stride_d = stride_q;
    base_d   = base_q;
    done_d   = 1'b0;
    if (cfg_fire) begin
      bound_d  = cfg_bound;
      stride_d = cfg_stride;
      base_d   = cfg_base;
    end
    case (state_q)
      LN_IDLE: begin
        if (cfg_fire) state_d = LN_ARMED;
      end
      LN_ARMED: begin
        if (start_fire) state_d = LN_RUN;
      end
      LN_RUN: begin
        if (abort_fire) begin
          state_d = LN_ARMED;
        end else if (finish) begin
          state_d = LN_ARMED;
          done_d  = 1'b1;
        end
      end
      default: state_d = LN_IDLE;
    endcase
  end

  // FSM and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LN_IDLE;
      // NOTE: the config bank is small and reset so a run can never start from stale values after reset.
      bound_q  <= '0;
      stride_q <= '0;
      base_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bound_q  <= bound_d;
      stride_q <= stride_d;
      base_q   <= base_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready = !run;
  assign idx       = idx_w;
  assign addr      = lb_w[0];
  assign wrap      = wrap_c;
  assign last      = last_w;
  assign busy      = run;
  assign done      = done_q;

endmodule

// File: tb/tb_loop_nest_counter.sv
// Directed self-checking bench for loop_nest_counter (3 levels, 32-bit).
module tb_loop_nest_counter;

  logic              clk;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0][31:0]  cfg_bound;
  logic [2:0][31:0]  cfg_stride;
  logic [31:0]       cfg_base;
  logic              start;
  logic              step;
  logic              abort;
  logic [2:0][31:0]  idx;
  logic [31:0]       addr;
  logic [2:0]        wrap;
  logic              last;
  logic              busy;
  logic              done;

  int n_asserts;
  int n_fail;

  logic [31:0] exp_addr [8];
  logic [31:0] exp_i0   [8];
  logic [31:0] exp_i1   [8];
  logic        chk_wrap0;

  loop_nest_counter #(
    .LEVELS (3),
    .WIDTH  (32),
    .ADDR_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_bound  (cfg_bound),
    .cfg_stride (cfg_stride),
    .cfg_base   (cfg_base),
    .start      (start),
    .step       (step),
    .abort      (abort),
    .idx        (idx),
    .addr       (addr),
    .wrap       (wrap),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                        input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] base);
    cfg_bound[0]  = b0;
    cfg_bound[1]  = b1;
    cfg_bound[2]  = b2;
    cfg_stride[0] = s0;
    cfg_stride[1] = s1;
    cfg_stride[2] = s2;
    cfg_base      = base;
    cfg_valid     = 1'b1;
    @(negedge clk);
    cfg_valid     = 1'b0;
  endtask

  // Start a run with step held high and walk the expected tuples, then the done pulse.
  task automatic run_held(input string tag, input int n);
    start = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < n; t++) begin
      check($sformatf("%s_addr%0d", tag, t), 64'(addr), 64'(exp_addr[t]));
      check($sformatf("%s_i0_%0d", tag, t), 64'(idx[0]), 64'(exp_i0[t]));
      check($sformatf("%s_i1_%0d", tag, t), 64'(idx[1]), 64'(exp_i1[t]));
      check($sformatf("%s_busy%0d", tag, t), 64'(busy), 64'd1);
      check($sformatf("%s_last%0d", tag, t), 64'(last), (t == n - 1) ? 64'd1 : 64'd0);
      check($sformatf("%s_done%0d", tag, t), 64'(done), 64'd0);
      if (chk_wrap0) check($sformatf("%s_wrap0_%0d", tag, t), 64'(wrap[0]), 64'd1);
      @(negedge clk);
    end
    step = 1'b0;
    check({tag, "_done_pulse"}, 64'(done), 64'd1);
    check({tag, "_done_busy"}, 64'(busy), 64'd0);
    check({tag, "_hold_addr"}, 64'(addr), 64'(exp_addr[n-1]));
    check({tag, "_hold_i0"}, 64'(idx[0]), 64'(exp_i0[n-1]));
    @(negedge clk);
    check({tag, "_done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    n_asserts  = 0;
    n_fail     = 0;
    chk_wrap0  = 1'b0;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_bound  = '0;
    cfg_stride = '0;
    cfg_base   = '0;
    start      = 1'b0;
    step       = 1'b0;
    abort      = 1'b0;

    // Reset state.
    #3;
    check("rst_idx", 64'(idx), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Start while unconfigured is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_start_busy", 64'(busy), 64'd0);

    // Bounds {2,3,1}, strides {1,16,256}, base 0x100, step held.
    do_cfg(32'd2, 32'd3, 32'd1, 32'd1, 32'd16, 32'd256, 32'h100);
    check("cfg_busy", 64'(busy), 64'd0);
    exp_addr[0] = 32'h100; exp_i0[0] = 0; exp_i1[0] = 0;
    exp_addr[1] = 32'h101; exp_i0[1] = 1; exp_i1[1] = 0;
    exp_addr[2] = 32'h110; exp_i0[2] = 0; exp_i1[2] = 1;
    exp_addr[3] = 32'h111; exp_i0[3] = 1; exp_i1[3] = 1;
    exp_addr[4] = 32'h120; exp_i0[4] = 0; exp_i1[4] = 2;
    exp_addr[5] = 32'h121; exp_i0[5] = 1; exp_i1[5] = 2;
    run_held("held", 6);

    // Same config, step toggling 1,0,1,0.
    begin
      int  t;
      bit  fin;
      t     = 0;
      fin   = 1'b0;
      start = 1'b1;
      step  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("tog_wrap_t0", 64'(wrap), 64'b000);
      for (int c = 0; c < 20 && !fin; c++) begin
        check($sformatf("tog_addr_c%0d", c), 64'(addr), 64'(exp_addr[t]));
        check($sformatf("tog_busy_c%0d", c), 64'(busy), 64'd1);
        check($sformatf("tog_done_c%0d", c), 64'(done), 64'd0);
        if (t == 1) check($sformatf("tog_wrap_c%0d", c), 64'(wrap), 64'b001);
        if (t == 5) check($sformatf("tog_wrapall_c%0d", c), 64'(wrap), 64'b111);
        step = (c % 2 == 0);
        @(negedge clk);
        if (step) begin
          if (t == 5) fin = 1'b1;
          else        t++;
        end
      end
      step = 1'b0;
      check("tog_finished", 64'(fin), 64'd1);
      check("tog_done", 64'(done), 64'd1);
      check("tog_done_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end

    // Zero bound at level 0: bounds {0,4,1}.
    do_cfg(32'd0, 32'd4, 32'd1, 32'd1, 32'd16, 32'd256, 32'h200);
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 32'h200 + 32'(16 * i);
      exp_i0[i]   = 32'd0;
      exp_i1[i]   = 32'(i);
    end
    chk_wrap0 = 1'b1;
    run_held("zb", 4);
    chk_wrap0 = 1'b0;

    // Abort together with step at tuple 3.
    do_cfg(32'd2, 32'd3, 32'd1, 32'd1, 32'd16, 32'd256, 32'h100);
    start = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ab_pre_addr", 64'(addr), 64'h111);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    step  = 1'b0;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_done", 64'(done), 64'd0);
    check("ab_cfg_ready", 64'(cfg_ready), 64'd1);
    check("ab_addr", 64'(addr), 64'h111);
    check("ab_i0", 64'(idx[0]), 64'd1);
    check("ab_i1", 64'(idx[1]), 64'd1);
    @(negedge clk);
    check("ab_no_late_done", 64'(done), 64'd0);
    start = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ab_restart_addr", 64'(addr), 64'h100);
    check("ab_restart_idx", 64'(idx), 64'd0);
    check("ab_restart_busy", 64'(busy), 64'd1);

    // Reset mid-run at tuple 2.
    @(negedge clk);
    @(negedge clk);
    check("mr_pre_addr", 64'(addr), 64'h110);
    step  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_idx", 64'(idx), 64'd0);
    check("mr_addr", 64'(addr), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_cfg_ready", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mr_start_ignored", 64'(busy), 64'd0);
    check("mr_start_addr", 64'(addr), 64'd0);

    // Config and start in the same ARMED cycle: config wins, start ignored.
    do_cfg(32'd2, 32'd3, 32'd1, 32'd1, 32'd16, 32'd256, 32'h100);
    cfg_bound[0]  = 32'd3;
    cfg_bound[1]  = 32'd1;
    cfg_bound[2]  = 32'd1;
    cfg_stride[0] = 32'd4;
    cfg_stride[1] = 32'd0;
    cfg_stride[2] = 32'd0;
    cfg_base      = 32'h400;
    cfg_valid     = 1'b1;
    start         = 1'b1;
    @(negedge clk);
    cfg_valid     = 1'b0;
    start         = 1'b0;
    check("cs_busy", 64'(busy), 64'd0);
    check("cs_cfg_ready", 64'(cfg_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      exp_addr[i] = 32'h400 + 32'(4 * i);
      exp_i0[i]   = 32'(i);
      exp_i1[i]   = 32'd0;
    end
    run_held("cs", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_nest_counter.md
# loop_nest_counter

- Parametrised N-level nested loop counter with per-level address-stride generation, for the TPU tile sequencer.
- Level 0 is the innermost loop.
- Software programs per-level trip counts, strides and a base address, then starts a run. The block emits one index tuple and one linear address per `step` until the whole nest completes.
- Replaces the fixed two-level counter/subcounter pair used to drive systolic-array operand fetch.

## Interface
Parameters:
- `LEVELS`, 3, number of nested loop levels (1..8)
- `WIDTH`, 32, width of each trip count and index
- `ADDR_W`, 32, width of base, stride and address

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `cfg_valid` in 1: configuration offer
- `cfg_ready` out 1: configuration accepted when high with `cfg_valid`
- `cfg_bound` in `[LEVELS][WIDTH]`: per-level trip count
- `cfg_stride` in `[LEVELS][ADDR_W]`: per-level address increment
- `cfg_base` in `ADDR_W`: start address
- `start` in 1: begin a run using the held configuration
- `step` in 1: advance one iteration (stall when low)
- `abort` in 1: terminate the run
- `idx` out `[LEVELS][WIDTH]`: current index per level
- `addr` out `ADDR_W`: current linear address
- `wrap` out `[LEVELS]`: level k wraps on the next `step`
- `last` out 1: current tuple is the final one of the nest
- `busy` out 1: state is RUN
- `done` out 1: one-cycle pulse after the final step

## Operation
States: IDLE (unconfigured), ARMED (configuration held), RUN.
- Reset: state IDLE; `idx`, `addr`, `done` are 0; internal config registers are 0.
- `cfg_ready` = (state != RUN), so it reads 1 during and after reset.
- Config handshake:
  - On `cfg_valid && cfg_ready`, capture bound/stride/base and go to ARMED.
  - A handshake in ARMED overwrites the held config.
- `start`:
  - Ignored in IDLE and RUN.
  - In ARMED: `idx`=0, `addr`=base, go to RUN.
  - If a config handshake occurs in the same cycle, the config is captured and `start` is ignored.
- Effective bound `eb[k]` = max(bound[k],1); a bound of 0 behaves as 1.
- `wrap[k]` = AND over j≤k of (`idx[j]` == `eb[j]`-1). Combinational, valid in all states; only meaningful in RUN.
- `last` = `wrap[LEVELS-1]` && busy.
- `step` in RUN, not last:
  - m = lowest level with `wrap[m]`=0.
  - `idx[m]`+1; `idx[j]`=0 for j<m; levels above m hold.
- Address: per-level base registers `lb[k]`, with `addr` = `lb[0]`.
  - On a step with pivot m: `lb[m]` += `stride[m]`, and `lb[j]` = new `lb[m]` for j<m.
  - All start/base loads set every `lb` to base.
  - Arithmetic is modulo 2^ADDR_W.
- `step` in RUN with `last`:
  - Go to ARMED; `done`=1 for one cycle.
  - `idx`/`addr` hold their final values until the next `start`.
- `abort` in RUN: go to ARMED with no `done`; `idx`/`addr` hold. `abort` has priority over `step`. `abort` is ignored outside RUN.
- `step` outside RUN is ignored.
- Reset asserted mid-run returns to IDLE immediately, and the config is lost.

## Timing
- Start to first valid tuple: `idx`/`addr` are valid on the cycle after `start` is sampled, with `busy`=1.
- One tuple per `step` cycle, with no bubbles at wrap points.
- A full run takes exactly Π eb[k] tuples and Π eb[k]−1 advancing steps before the final step.
- `done` is asserted in the cycle following the final step, coincident with `busy`=0.
- A new `start` is accepted in the same cycle `done` is high.
- All outputs are registered except `cfg_ready`, `wrap`, `last`, which are decoded from registers with no input-to-output combinational path.

## Structure
- Package `loop_nest_pkg`:
  - state enum `ln_state_e` {LN_IDLE, LN_ARMED, LN_RUN}
  - `LN_MAX_LEVELS`=8
  - function `eff_bound` (max with 1)
- Sub-module `loop_level`, generated LEVELS times:
  - Holds one index register and one `lb` register.
  - Inputs: `carry_in`, `pivot`, `load_base`, `new_base`.
  - Outputs: `idx`, `at_end`, `lb`.
- Top level holds config registers, the FSM, the pivot priority encoder, and `done`.

## Test plan
- Bounds {2,3,1}, strides {1,16,256}, base 0x100, step held high:
  - 6 tuples.
  - `addr` sequence 0x100,0x101,0x110,0x111,0x120,0x121.
  - `done` pulses one cycle after the 6th tuple, with `busy`=0.
- Same config with `step` toggling 1,0,1,0:
  - Tuples change only on step cycles.
  - Total 6 tuples, with `done` timing relative to the final step unchanged.
- Bound[0]=0 with bounds {0,4,1}:
  - Level 0 stays at 0, `wrap[0]` is constantly 1.
  - 4 tuples; `idx[1]` goes 0..3.
- `abort` together with `step` at tuple 3:
  - State ARMED, no `done`, `idx` held.
  - A subsequent `start` restarts at idx 0, `addr` = base.
- `rst_n` low mid-run (tuple 2):
  - All outputs are 0 asynchronously, `cfg_ready`=1.
  - `start` before reconfiguration is ignored.
- `cfg_valid` and `start` in the same cycle in ARMED:
  - The new config is captured and `busy` stays 0.
  - The next `start` runs with the new bounds.
